ftsd_scan_capture: RTL
======================

// Module: ftsd_scan_capture
// PURPOSE
//   Receive end of the 14-segment scan bus. Watches the time-multiplexed
//   digit-select (active-low one-hot) and BCD data lines and rebuilds the four
//   digit values. It delivers one complete, consistent 4-digit frame per
//   scan round. Used for board loopback checks and for snooping an external
//   scanned display.
// PARAMETERS
//   BCD_W        4      width of per-digit data (matches `BCD_BIT_WIDTH)
//   FTSD_NUM     4      number of digits / select lines (fixed 4 in this rev)
//   STABLE_CYC   4      consecutive identical samples required to accept a digit (>=2)
//   TIMEOUT_CYC  65535  cycles with no accepted frame before scan_lost asserts
// PORTS
//   clk          in   1          system clock, rising edge
//   rst          in   1          asynchronous reset, active-high
//   ftsd_ctl     in   FTSD_NUM   digit select: 0111=d0, 1011=d1, 1101=d2, 1110=d3
//   ftsd_in      in   BCD_W      data for the currently selected digit
//   out0..out3   out  BCD_W      last complete frame, digits 0..3
//   frame_valid  out  1          1-cycle pulse: out0..out3 just updated
//   seq_err      out  1          1-cycle pulse: digit accepted out of scan order
//   scan_lost    out  1          level: no frame for TIMEOUT_CYC cycles
// BEHAVIOUR
//   - Reset: out0..out3=0, shadow regs=0, frame_valid=seq_err=0, scan_lost=0.
//     FSM goes to SEARCH, run counter=0, timeout counter=0. Reset is honoured
//     mid-frame: partial shadow data is discarded.
//   - Input stage: {ftsd_ctl,ftsd_in} is registered every edge as prev.
//   - Valid select: exactly one 0 bit in ftsd_ctl. 1111, 0000 and any pattern
//     with multiple zeros are invalid.
//   - Run length L: at each edge, if the input pair is valid and equals prev,
//     L increments and saturates at STABLE_CYC. Otherwise L is set to 1 if the
//     pair is valid, or 0 if it is invalid.
//   - Accept event: fires at the single edge where L becomes STABLE_CYC, so a
//     dwell is accepted at most once. Data changes inside a dwell restart L.
//     Glitches shorter than STABLE_CYC edges are never accepted.
//   - FSM states: SEARCH, EXP1, EXP2, EXP3.
//       SEARCH: accept d0 -> shadow0, go to EXP1. Accept of d1..d3 is ignored
//               (no seq_err).
//       EXPn:   accept dn -> shadown, go to EXP(n+1). In EXP3, accepting d3
//               copies shadow0..2 and the d3 data into out0..out3 together,
//               pulses frame_valid, and returns to SEARCH.
//               Accept of d0 -> seq_err pulse, shadow0 reloaded, go to EXP1.
//               Accept of any other wrong digit -> seq_err pulse, go to SEARCH.
//   - Outputs are registered. out*/frame_valid/seq_err change on the edge
//     after the accept edge (latency 1 cycle from accept).
//   - out0..out3 hold between frames and never show a partial frame.
//   - Timeout counter: cleared on each frame_valid, otherwise increments and
//     saturates. scan_lost=1 when the count reaches TIMEOUT_CYC.
//     scan_lost=0 on the cycle frame_valid pulses. The FSM also returns to
//     SEARCH when the count reaches TIMEOUT_CYC.
//   - Simultaneous timeout and accept: the accept wins and the FSM advances.
//     If that accept completes a frame, scan_lost clears.
// TESTING
//   1 Ideal scan, dwell 8 cycles, d0..d3 = 1,2,3,4 -> single frame_valid 1
//     cycle after d3's 4th edge; out0..3 = 1,2,3,4; seq_err never pulses.
//   2 Same scan with a 2-cycle glitch (ctl=1011, data 9) inside the d0 dwell
//     -> glitch not accepted; frame still 1,2,3,4.
//   3 Sequence d0,d2 (dwell 8) -> seq_err pulse on d2 accept; FSM in SEARCH;
//     out* unchanged; the next clean round produces a frame.
//   4 ctl=1111 for 3 cycles between digits, and ctl=0011 held 10 cycles
//     -> no accept during either; L restarts; frame completes normally.
//   5 TIMEOUT_CYC=100, stop scanning after one frame -> scan_lost=1 at cycle
//     100 after frame_valid; the next complete round clears it with frame_valid.
//   6 Assert rst while in EXP2 -> all outputs 0 immediately (async); a
//     following round of 5,6,7,8 yields out=5,6,7,8 with no stale shadow data.

Source files
------------

// File: rtl/ftsd_scan_capture_if.sv
// Scan-bus bundle for the 14-segment receive capture block: the observed
// digit-select/data lines plus the rebuilt frame and status outputs.
interface ftsd_scan_capture_if #(
    parameter int BCD_W    = 4,
    parameter int FTSD_NUM = 4
);
    logic [FTSD_NUM-1:0] ftsd_ctl;
    logic [BCD_W-1:0]    ftsd_in;
    logic [BCD_W-1:0]    out0;
    logic [BCD_W-1:0]    out1;
    logic [BCD_W-1:0]    out2;
    logic [BCD_W-1:0]    out3;
    logic                frame_valid;
    logic                seq_err;
    logic                scan_lost;

    // Scan source side: drives the bus, observes the captured frame.
    modport master (
        output ftsd_ctl, ftsd_in,
        input  out0, out1, out2, out3, frame_valid, seq_err, scan_lost
    );

    // Capture side: observes the bus, produces the captured frame.
    modport slave (
        input  ftsd_ctl, ftsd_in,
        output out0, out1, out2, out3, frame_valid, seq_err, scan_lost
    );
endinterface

// File: rtl/ftsd_scan_capture.sv
// Receive end of the scanned 4-digit display bus. A digit is accepted once
// its select/data pair has been stable for STABLE_CYC edges; accepted digits
// are assembled in scan order into shadow registers and published together.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SEARCH | waiting for an accepted d0 to start a frame
// EXP1   | d0 captured, expecting d1
// EXP2   | d0..d1 captured, expecting d2
// EXP3   | d0..d2 captured, expecting d3 (completes and publishes)
module ftsd_scan_capture #(
    parameter int BCD_W       = 4,
    parameter int FTSD_NUM    = 4,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    ftsd_scan_capture_if.slave   bus
);
    localparam int DIG_W = $clog2(FTSD_NUM);
    localparam int RUN_W = $clog2(STABLE_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {SEARCH, EXP1, EXP2, EXP3} state_t;

    state_t              state_q, state_nxt;
    logic [FTSD_NUM-1:0] prev_ctl;
    logic [BCD_W-1:0]    prev_dat;
    logic [RUN_W-1:0]    run_q, run_nxt;
    logic                cur_valid;
    logic [DIG_W-1:0]    cur_digit;
    logic                accept;
    logic                acc_q;
    logic [DIG_W-1:0]    acc_digit_q;
    logic [BCD_W-1:0]    acc_dat_q;
    logic [BCD_W-1:0]    sh0, sh1, sh2;
    logic [BCD_W-1:0]    out0_q, out1_q, out2_q, out3_q;
    logic                frame_valid_q, seq_err_q;
    logic                ld_shadow, frame_done, seq_err_nxt;
    logic [TMO_W-1:0]    tmo_q;
    logic                tmo_expiring;

    // Decode the one-hot-low select into a digit index; anything else is invalid.
    always_comb begin
        cur_valid = 1'b0;
        cur_digit = '0;
        case (bus.ftsd_ctl)
            4'b0111: begin cur_valid = 1'b1; cur_digit = 2'd0; end
            4'b1011: begin cur_valid = 1'b1; cur_digit = 2'd1; end
            4'b1101: begin cur_valid = 1'b1; cur_digit = 2'd2; end
            4'b1110: begin cur_valid = 1'b1; cur_digit = 2'd3; end
            default: ;
        endcase
    end

    // Run length of identical valid samples, saturating so a dwell fires once.
    always_comb begin
        run_nxt = cur_valid ? RUN_W'(1) : '0;
        if (cur_valid && (bus.ftsd_ctl == prev_ctl) && (bus.ftsd_in == prev_dat))
            run_nxt = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
    end

    assign accept = (run_nxt == RUN_MAX) && (run_q != RUN_MAX);

    // Input stage: previous sample, run length and the registered accept event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ctl    <= '0;
            prev_dat    <= '0;
            run_q       <= '0;
            acc_q       <= 1'b0;
            acc_digit_q <= '0;
            acc_dat_q   <= '0;
        end else begin
            prev_ctl    <= bus.ftsd_ctl;
            prev_dat    <= bus.ftsd_in;
            run_q       <= run_nxt;
            acc_q       <= accept;
            acc_digit_q <= cur_digit;
            acc_dat_q   <= bus.ftsd_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SEARCH;
        else     state_q <= state_nxt;
    end

    // Next state: the expected digit index equals the state encoding; a
    // timeout only resyncs the FSM when no accept is competing for the edge.
    always_comb begin
        state_nxt   = state_q;
        ld_shadow   = 1'b0;
        frame_done  = 1'b0;
        seq_err_nxt = 1'b0;
        if (acc_q) begin
            if (acc_digit_q == DIG_W'(state_q)) begin
                if (state_q == EXP3) begin
                    frame_done = 1'b1;
                    state_nxt  = SEARCH;
                end else begin
                    ld_shadow = 1'b1;
                    state_nxt = state_t'(state_q + 2'd1);
                end
            end else if (state_q != SEARCH) begin
                seq_err_nxt = 1'b1;
                if (acc_digit_q == '0) begin
                    ld_shadow = 1'b1;
                    state_nxt = EXP1;
                end else begin
                    state_nxt = SEARCH;
                end
            end
        end else if (tmo_expiring) begin
            state_nxt = SEARCH;
        end
    end

    // Shadow capture and atomic publication of the completed frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh0           <= '0;
            sh1           <= '0;
            sh2           <= '0;
            out0_q        <= '0;
            out1_q        <= '0;
            out2_q        <= '0;
            out3_q        <= '0;
            frame_valid_q <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            frame_valid_q <= frame_done;
            seq_err_q     <= seq_err_nxt;
            if (ld_shadow) begin
                case (acc_digit_q)
                    2'd0:    sh0 <= acc_dat_q;
                    2'd1:    sh1 <= acc_dat_q;
                    2'd2:    sh2 <= acc_dat_q;
                    default: ;
                endcase
            end
            if (frame_done) begin
                out0_q <= sh0;
                out1_q <= sh1;
                out2_q <= sh2;
                out3_q <= acc_dat_q;
            end
        end
    end

    // Frame watchdog as a down-counter: reloads on each frame, zero means lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                tmo_q <= TMO_MAX;
        else if (frame_done)    tmo_q <= TMO_MAX;
        else if (tmo_q != '0)   tmo_q <= tmo_q - TMO_W'(1);
    end

    assign tmo_expiring    = (tmo_q == TMO_W'(1));
    assign bus.scan_lost   = (tmo_q == '0);
    assign bus.out0        = out0_q;
    assign bus.out1        = out1_q;
    assign bus.out2        = out2_q;
    assign bus.out3        = out3_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.seq_err     = seq_err_q;
endmodule
